// File: rtl/inst_rom_arb_pkg.sv
// Shared definitions for the instruction-ROM arbiter: bus widths, chip-enable
// and reset levels, the zero word, the priority-state encoding and the
// starvation-counter limits.
package inst_rom_arb_pkg;

    localparam int unsigned InstAddrBusW = 32;
    localparam int unsigned InstBusW     = 32;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam logic [InstBusW-1:0] ZeroWord = '0;

    localparam int unsigned         StarveW   = 4;
    localparam logic [StarveW-1:0]  StarveMax = 4'd15;

    // Which port wins the next contested cycle.
    typedef enum logic {
        PriIf = 1'b0,
        PriLd = 1'b1
    } pri_e;

    // Word accesses only: any set byte-offset bit makes the address illegal.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/inst_rom_arb.sv
// inst_rom_arb: two-port arbiter in front of a combinational single-port ROM.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   if_req/if_addr -> if_gnt      instruction-fetch request and same-cycle grant
//   if_rvalid/if_rdata/if_err     fetch response, one cycle after the grant
//   ld_req/ld_addr -> ld_gnt      data-side constant-load request and grant
//   ld_rvalid/ld_rdata/ld_err     load response, one cycle after the grant
//   rom_ce/rom_addr <- rom_inst   ROM access for the granted port
//   stallreq                      fetch is requesting but not granted
//
// Build option
//   INST_ROM_ARB_RR_EN  defined: contested grants alternate between the ports.
//                       undefined: fetch always wins contention (state held at
//                       PriIf); the load starvation guard stays active either way.
module inst_rom_arb
    import inst_rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = InstAddrBusW,
    parameter int unsigned DATA_W = InstBusW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    output logic              stallreq
);

    logic              rst_act;
    pri_e              pri_q, pri_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic              contest, if_win, ld_win;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_any, gnt_mis;

    logic              if_rvalid_q, if_err_q, ld_rvalid_q, ld_err_q;
    logic [DATA_W-1:0] if_rdata_q, ld_rdata_q;

    assign rst_act = (rst == RstEnable);

    // Priority state register.
    always_ff @(posedge clk) begin
        if (rst_act) begin
            pri_q <= PriIf;
        end else begin
            pri_q <= pri_d;
        end
    end

    // Next priority state: the loser of a contested grant gets the next turn.
    always_comb begin
        pri_d = pri_q;
`ifdef INST_ROM_ARB_RR_EN
        if (contest) begin
            pri_d = ld_win ? PriIf : PriLd;
        end
`else
        pri_d = PriIf;
`endif
    end

    // Arbitration outputs. A saturated starvation counter overrides the state.
    always_comb begin
        contest = if_req & ld_req;
        if_win  = 1'b0;
        ld_win  = 1'b0;
        if (contest) begin
            if (starve_q == StarveMax || pri_q == PriLd) begin
                ld_win = 1'b1;
            end else begin
                if_win = 1'b1;
            end
        end else begin
            if_win = if_req;
            ld_win = ld_req;
        end
    end

    assign if_gnt   = if_win & ~rst_act;
    assign ld_gnt   = ld_win & ~rst_act;
    assign stallreq = if_req & ~if_gnt & ~rst_act;

    assign gnt_addr = ld_gnt ? ld_addr : if_addr;
    assign gnt_any  = if_gnt | ld_gnt;
    assign gnt_mis  = is_misaligned(gnt_addr[1:0]);
    // Misaligned grants are answered with an error and never touch the ROM.
    assign rom_ce   = (gnt_any && !gnt_mis) ? ChipEnable : ChipDisable;
    assign rom_addr = (gnt_any && !gnt_mis) ? gnt_addr : '0;

    always_comb begin
        starve_d = starve_q;
        if (ld_gnt) begin
            starve_d = '0;
        end else if (ld_req && starve_q != StarveMax) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Response registers: rvalid/err pulse for one cycle, rdata holds.
    always_ff @(posedge clk) begin
        if (rst_act) begin
            starve_q    <= '0;
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= DATA_W'(ZeroWord);
            ld_rvalid_q <= 1'b0;
            ld_err_q    <= 1'b0;
            ld_rdata_q  <= DATA_W'(ZeroWord);
        end else begin
            starve_q    <= starve_d;
            if_rvalid_q <= if_gnt;
            if_err_q    <= if_gnt & gnt_mis;
            ld_rvalid_q <= ld_gnt;
            ld_err_q    <= ld_gnt & gnt_mis;
            if (if_gnt) begin
                if_rdata_q <= gnt_mis ? DATA_W'(ZeroWord) : rom_inst;
            end
            if (ld_gnt) begin
                ld_rdata_q <= gnt_mis ? DATA_W'(ZeroWord) : rom_inst;
            end
        end
    end

    // Responses read as reset values for as long as reset is held.
    assign if_rvalid = if_rvalid_q & ~rst_act;
    assign if_err    = if_err_q & ~rst_act;
    assign if_rdata  = rst_act ? DATA_W'(ZeroWord) : if_rdata_q;
    assign ld_rvalid = ld_rvalid_q & ~rst_act;
    assign ld_err    = ld_err_q & ~rst_act;
    assign ld_rdata  = rst_act ? DATA_W'(ZeroWord) : ld_rdata_q;

endmodule

// File: doc/inst_rom_arb.md
INST_ROM_ARB -- requirements
Module: inst_rom_arb

Interface
- REQ-001 SHALL have parameter ADDR_W, default 32: width of the requester and ROM address buses (`InstAddrBus`).
- REQ-002 SHALL have parameter DATA_W, default 32: width of the instruction/data word (`InstBus`).
- REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high (`RstEnable` = 1'b1).
- REQ-005 SHALL have ports if_req in 1, if_addr in ADDR_W, if_gnt out 1, if_rvalid out 1, if_rdata out DATA_W, if_err out 1: the instruction-fetch requester.
- REQ-006 SHALL have ports ld_req in 1, ld_addr in ADDR_W, ld_gnt out 1, ld_rvalid out 1, ld_rdata out DATA_W, ld_err out 1: the data-side read requester (constant/literal loads from ROM).
- REQ-007 SHALL have ports rom_ce out 1, rom_addr out ADDR_W, rom_inst in DATA_W: the combinational single-port ROM.
- REQ-008 SHALL have port stallreq out 1: a pipeline stall request asserted while fetch is pending but not granted.

Function
- REQ-009 SHALL grant at most one requester per cycle; the grant is combinational from the current req and the priority state.
- REQ-010 SHALL, on a grant, drive rom_ce=`ChipEnable` and rom_addr=the granted address in the same cycle; otherwise rom_ce=`ChipDisable` and rom_addr=0.
- REQ-011 SHALL register rom_inst into the granted port's rdata and pulse its rvalid exactly one cycle after the grant (latency 1); the rdata value is held until the next rvalid on that port.
- REQ-012 SHALL require the requester to hold req and its address stable until gnt; the deassertion of req before gnt SHALL cancel the request without ROM access.
- REQ-013 SHALL treat an address with addr[1:0]!=0 as misaligned: grant it, keep rom_ce disabled, return rdata=`ZeroWord` with rvalid=1 and err=1 one cycle later.
- REQ-014 SHALL maintain a 2-state priority FSM, PRI_IF and PRI_LD; on contention, the port named by the state wins, and after a contested grant the state moves to the other port; an uncontested grant leaves the state unchanged.
- REQ-015 SHALL assert stallreq = if_req & ~if_gnt, combinationally.
- REQ-016 SHALL maintain a 4-bit starvation counter that increments each cycle ld_req is denied, saturates at 15 and clears on ld_gnt; at 15, ld SHALL win regardless of the priority state.
- REQ-017 SHALL allow back-to-back grants every cycle, including alternating ports, with no bubble.

Reset
- REQ-018 SHALL, while rst=1, force FSM=PRI_IF, starvation counter=0, all gnt/rvalid/err=0, all rdata=`ZeroWord`, rom_ce=`ChipDisable`, stallreq=0.
- REQ-019 SHALL discard any read granted in the cycle that rst asserts; no rvalid SHALL appear in the cycle after reset releases.

Configuration
- REQ-020 SHALL honour the macro INST_ROM_ARB_RR_EN: defined -> alternating FSM of REQ-014; undefined -> fixed priority to if, FSM held at PRI_IF, starvation guard of REQ-016 still active.

Structure
- REQ-021 SHALL take ChipEnable/ChipDisable, ZeroWord, RstEnable, bus widths and the PRI_IF/PRI_LD state encodings from the shared defines file.
- REQ-022 SHALL be a single module with no sub-modules; the ROM is instantiated beside it, not inside it.

Verification
- REQ-023 SHALL check: only if_req=1, if_addr=0x4 -> if_gnt same cycle, rom_addr=0x4, if_rvalid=1 with if_rdata=ROM[1] the next cycle, stallreq=0.
- REQ-024 SHALL check: if_req and ld_req both held for 4 cycles under RR_EN -> grants alternate if, ld, if, ld; stallreq=1 exactly on ld cycles.
- REQ-025 SHALL check: with RR_EN undefined, both req held 17 cycles -> ld denied 15 cycles, then ld_gnt on cycle 16 and counter returns to 0.
- REQ-026 SHALL check: ld_addr=0x6 -> ld_gnt, rom_ce=0, next cycle ld_rvalid=1, ld_err=1, ld_rdata=0x00000000.
- REQ-027 SHALL check: rst asserted in the cycle of an if grant -> no if_rvalid afterward, all outputs at reset values, FSM=PRI_IF.
